// File: rtl/dmd_scan_driver_if.sv
// rtl/dmd_scan_driver_if.sv - write/swap and display-drive signals of the dot-matrix scan driver
interface dmd_scan_driver_if;
  logic        wr_en;
  logic [3:0]  wr_row;
  logic [15:0] wr_data;
  logic        swap_req;
  logic        swap_ack;
  logic        frame_start;
  logic [3:0]  dmd_seg;
  logic [15:0] dmd_column;
  logic        DMD_CLR;
  logic        DMD_CLK;

  modport master (
    output wr_en, wr_row, wr_data, swap_req,
    input  swap_ack, frame_start, dmd_seg, dmd_column, DMD_CLR, DMD_CLK
  );

  modport slave (
    input  wr_en, wr_row, wr_data, swap_req,
    output swap_ack, frame_start, dmd_seg, dmd_column, DMD_CLR, DMD_CLK
  );
endinterface

// File: rtl/dmd_scan_driver.sv
// rtl/dmd_scan_driver.sv - double-buffered 16x16 dot-matrix row scanner with tear-free swap
module dmd_scan_driver #(
  parameter int ROW_HOLD  = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic CLK,
  input  logic RESET,
  dmd_scan_driver_if.slave bus
);

  localparam int CNT_MAX = (ROW_HOLD > BLANK_CYC) ? ROW_HOLD : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(ROW_HOLD - 1);

  typedef enum logic [1:0] {ST_BLANK, ST_LATCH, ST_SHOW} state_t;

  // State registers describe the cycle whose outputs are loaded at the next edge.
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_row;
  logic          r_sel;
  logic          r_pending;
  logic          r_fresh;
  logic [15:0]   r_buf [2][16];

  logic [3:0]    r_seg;
  logic [15:0]   r_col;
  logic          r_clr;
  logic          r_clk;
  logic          r_ack;
  logic          r_fs;

  logic          w_frame_edge;
  logic          w_swap;
  logic [15:0]   w_front_row;

  // The first frame after reset has no preceding row 15, so it never swaps.
  assign w_frame_edge = (r_state == ST_BLANK) && (r_cnt == '0) && (r_row == 4'd0) && !r_fresh;
  assign w_swap       = w_frame_edge && (r_pending || bus.swap_req);

  // On a swap the new front is the old back, including a write landing this same edge.
  always_comb begin
    w_front_row = r_buf[r_sel][r_row];
    if (w_swap) begin
      w_front_row = r_buf[~r_sel][r_row];
      if (bus.wr_en && (bus.wr_row == r_row)) begin
        w_front_row = bus.wr_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_BLANK;
      r_cnt     <= '0;
      r_row     <= 4'd0;
      r_sel     <= 1'b0;
      r_pending <= 1'b0;
      r_fresh   <= 1'b1;
      r_seg     <= 4'd0;
      r_col     <= 16'd0;
      r_clr     <= 1'b1;
      r_clk     <= 1'b0;
      r_ack     <= 1'b0;
      r_fs      <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 16; i++) begin
          r_buf[b][i] <= 16'd0;
        end
      end
    end else begin
      r_fresh <= 1'b0;
      r_ack   <= w_swap;
      r_fs    <= 1'b0;

      if (bus.wr_en) begin
        r_buf[~r_sel][bus.wr_row] <= bus.wr_data;
      end

      if (w_swap) begin
        r_sel     <= ~r_sel;
        r_pending <= 1'b0;
      end else if (bus.swap_req) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_BLANK: begin
          r_clr <= 1'b1;
          r_clk <= 1'b0;
          if (r_cnt == '0) begin
            r_seg <= r_row;
            r_col <= w_front_row;
            r_fs  <= (r_row == 4'd0);
          end
          if (r_cnt == BLANK_LAST) begin
            r_state <= ST_LATCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_LATCH: begin
          r_clr   <= 1'b1;
          r_clk   <= 1'b1;
          r_state <= ST_SHOW;
          r_cnt   <= '0;
        end
        ST_SHOW: begin
          r_clr <= 1'b0;
          r_clk <= 1'b0;
          if (r_cnt == SHOW_LAST) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_row   <= r_row + 4'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.dmd_seg     = r_seg;
  assign bus.dmd_column  = r_col;
  assign bus.DMD_CLR     = r_clr;
  assign bus.DMD_CLK     = r_clk;
  assign bus.swap_ack    = r_ack;
  assign bus.frame_start = r_fs;

endmodule
